// File: rtl/ihex_pkg.sv
// Shared Intel HEX definitions used by the encoder and decoder paths.
// Contents: record type codes, ASCII framing characters, the encoder FSM
// state enum, the record descriptor struct and a nibble-to-ASCII helper.
package ihex_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned UPPER_W = 16;
    localparam int unsigned NIB_W   = 3;

    localparam logic [BYTE_W-1:0] REC_DATA = 8'h00;
    localparam logic [BYTE_W-1:0] REC_EOF  = 8'h01;
    localparam logic [BYTE_W-1:0] REC_ELA  = 8'h04;
    localparam logic [BYTE_W-1:0] REC_SLA  = 8'h05;

    localparam logic [BYTE_W-1:0] ASCII_COLON = 8'h3A;
    localparam logic [BYTE_W-1:0] ASCII_CR    = 8'h0D;
    localparam logic [BYTE_W-1:0] ASCII_LF    = 8'h0A;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LATCH,
        ST_PLAN,
        ST_COLON,
        ST_HDR,
        ST_FETCH,
        ST_DHI,
        ST_DLO,
        ST_CSUM,
        ST_CR,
        ST_LF,
        ST_DONE
    } ihex_state_e;

    // One record being emitted; payload holds immediate data for 04/05 records
    typedef struct packed {
        logic [BYTE_W-1:0]  rtype;
        logic [BYTE_W-1:0]  len;
        logic [UPPER_W-1:0] addr;
        logic [ADDR_W-1:0]  payload;
    } ihex_rec_t;

    // Uppercase ASCII hex digit for a nibble
    function automatic logic [BYTE_W-1:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/ihex_record_planner.sv
// Chooses the next Intel HEX record from the encoder's progress.
// Ports: address/remaining (next data byte and bytes left), last_upper and
// upper_valid (last emitted 04 value), sa_pending/start_address (05 record
// still owed) -> rec_type, rec_len, rec_address, rec_payload.
module ihex_record_planner
    import ihex_pkg::*;
#(
    parameter int unsigned RECORD_BYTES = 16
) (
    input  logic [31:0] address,
    input  logic [31:0] remaining,
    input  logic [15:0] last_upper,
    input  logic        upper_valid,
    input  logic        sa_pending,
    input  logic [31:0] start_address,
    output logic [7:0]  rec_type,
    output logic [7:0]  rec_len,
    output logic [15:0] rec_address,
    output logic [31:0] rec_payload
);

    logic [31:0] to_boundary;
    logic [31:0] chunk;

    // Data record length: min(RECORD_BYTES, remaining, bytes to next 64 KiB boundary)
    always_comb begin
        to_boundary = 32'h0001_0000 - {16'h0000, address[15:0]};
        chunk       = 32'(RECORD_BYTES);
        if (remaining < chunk) begin
            chunk = remaining;
        end
        if (to_boundary < chunk) begin
            chunk = to_boundary;
        end
    end

    // Data first (with a 04 record whenever the upper half changes), then 05, then EOF
    always_comb begin
        rec_type    = REC_EOF;
        rec_len     = 8'd0;
        rec_address = 16'h0000;
        rec_payload = 32'h0000_0000;
        if (remaining != 32'd0) begin
            if (!upper_valid || (address[31:16] != last_upper)) begin
                rec_type    = REC_ELA;
                rec_len     = 8'd2;
                rec_payload = {address[31:16], 16'h0000};
            end else begin
                rec_type    = REC_DATA;
                rec_len     = chunk[7:0];
                rec_address = address[15:0];
            end
        end else if (sa_pending) begin
            rec_type    = REC_SLA;
            rec_len     = 8'd4;
            rec_payload = start_address;
        end
    end

endmodule

// File: rtl/ihex_encoder.sv
// Streams a memory byte range out as Intel HEX text, one character per
// tx handshake, reading memory one byte at a time with no record buffer.
// Ports: clock/reset_n; start + base_address/length/start_address/
// start_address_valid (latched on start); rd_req/rd_address/rd_data/rd_valid
// memory read port; tx_valid/tx_data/tx_ready character sink; busy, done.
module ihex_encoder
    import ihex_pkg::*;
#(
    parameter int unsigned RECORD_BYTES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] base_address,
    input  logic [31:0] length,
    input  logic [31:0] start_address,
    input  logic        start_address_valid,
    output logic        rd_req,
    output logic [31:0] rd_address,
    input  logic [7:0]  rd_data,
    input  logic        rd_valid,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    ihex_state_e state_q, state_d;

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  remaining_q, remaining_d;
    logic [ADDR_W-1:0]  start_addr_q, start_addr_d;
    logic [UPPER_W-1:0] upper_q, upper_d;
    logic               upper_valid_q, upper_valid_d;
    logic               sa_pending_q, sa_pending_d;
    logic               eof_q, eof_d;
    logic               rd_pending_q, rd_pending_d;
    ihex_rec_t          rec_q, rec_d;
    logic [BYTE_W-1:0]  left_q, left_d;
    logic [BYTE_W-1:0]  byte_q, byte_d;
    logic [BYTE_W-1:0]  csum_q, csum_d;
    logic [NIB_W-1:0]   nib_q, nib_d;

    logic               tx_valid_d, rd_req_d, busy_d, done_d;
    logic [BYTE_W-1:0]  tx_data_d;
    logic [ADDR_W-1:0]  rd_address_d;

    logic [BYTE_W-1:0]  p_type, p_len;
    logic [UPPER_W-1:0] p_addr;
    logic [ADDR_W-1:0]  p_payload;

    logic hs;
    logic mem_rec;
    logic byte_ready;
    logic rd_issue;

    ihex_record_planner #(
        .RECORD_BYTES(RECORD_BYTES)
    ) u_planner (
        .address      (addr_q),
        .remaining    (remaining_q),
        .last_upper   (upper_q),
        .upper_valid  (upper_valid_q),
        .sa_pending   (sa_pending_q),
        .start_address(start_addr_q),
        .rec_type     (p_type),
        .rec_len      (p_len),
        .rec_address  (p_addr),
        .rec_payload  (p_payload)
    );

    assign hs      = tx_valid & tx_ready;
    assign mem_rec = (rec_q.rtype == REC_DATA);
    // 04/05 records carry immediate data, so their bytes are ready at once
    assign byte_ready = mem_rec ? (rd_pending_q & rd_valid) : 1'b1;
    // One read per memory byte, issued on entry to FETCH
    assign rd_issue = (state_d == ST_FETCH) && (state_q != ST_FETCH) && mem_rec;

    // Character presented in a given state
    function automatic logic [7:0] char_of(input ihex_state_e st, input logic [2:0] nib,
                                           input logic [7:0] ll, input logic [15:0] aa,
                                           input logic [7:0] tt, input logic [7:0] db,
                                           input logic [7:0] cs);
        logic [31:0] hdr;
        logic [7:0]  cc;
        logic [7:0]  ch;
        hdr = {ll, aa, tt};
        cc  = 8'h00 - cs;
        ch  = 8'h00;
        case (st)
            ST_COLON: ch = ASCII_COLON;
            ST_HDR:   ch = hex_ascii(hdr[{3'd7 - nib, 2'b00} +: 4]);
            ST_DHI:   ch = hex_ascii(db[7:4]);
            ST_DLO:   ch = hex_ascii(db[3:0]);
            ST_CSUM:  ch = hex_ascii(nib[0] ? cc[3:0] : cc[7:4]);
            ST_CR:    ch = ASCII_CR;
            ST_LF:    ch = ASCII_LF;
            default:  ch = 8'h00;
        endcase
        return ch;
    endfunction

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; character states advance only on a handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LATCH;
            ST_LATCH: state_d = ST_PLAN;
            ST_PLAN:  state_d = ST_COLON;
            ST_COLON: if (hs) state_d = ST_HDR;
            ST_HDR: begin
                if (hs && (nib_q == 3'd7)) begin
                    state_d = (rec_q.len != 8'd0) ? ST_FETCH : ST_CSUM;
                end
            end
            ST_FETCH: if (byte_ready) state_d = ST_DHI;
            ST_DHI:   if (hs) state_d = ST_DLO;
            ST_DLO: begin
                if (hs) begin
                    state_d = (left_q != 8'd0) ? ST_FETCH : ST_CSUM;
                end
            end
            ST_CSUM:  if (hs && (nib_q == 3'd1)) state_d = ST_CR;
            ST_CR:    if (hs) state_d = ST_LF;
            ST_LF:    if (hs) state_d = eof_q ? ST_DONE : ST_PLAN;
            ST_DONE:  state_d = start ? ST_LATCH : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: parameter latch, record planning, byte capture
    always_comb begin
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        start_addr_d  = start_addr_q;
        upper_d       = upper_q;
        upper_valid_d = upper_valid_q;
        sa_pending_d  = sa_pending_q;
        eof_d         = eof_q;
        rd_pending_d  = rd_pending_q;
        rec_d         = rec_q;
        left_d        = left_q;
        byte_d        = byte_q;
        csum_d        = csum_q;
        nib_d         = nib_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    addr_d        = base_address;
                    remaining_d   = length;
                    start_addr_d  = start_address;
                    sa_pending_d  = start_address_valid;
                    upper_d       = 16'h0000;
                    upper_valid_d = 1'b0;
                    eof_d         = 1'b0;
                end
            end
            ST_PLAN: begin
                rec_d.rtype   = p_type;
                rec_d.len     = p_len;
                rec_d.addr    = p_addr;
                rec_d.payload = p_payload;
                left_d        = p_len;
                csum_d        = p_len + p_addr[15:8] + p_addr[7:0] + p_type;
                nib_d         = 3'd0;
                if (p_type == REC_ELA) begin
                    upper_d       = p_payload[31:16];
                    upper_valid_d = 1'b1;
                end
                if (p_type == REC_SLA) begin
                    sa_pending_d = 1'b0;
                end
                if (p_type == REC_EOF) begin
                    eof_d = 1'b1;
                end
            end
            // Nibble counter wraps to 0 after the last header nibble
            ST_HDR, ST_CSUM: begin
                if (hs) begin
                    nib_d = nib_q + 3'd1;
                end
            end
            ST_FETCH: begin
                if (byte_ready) begin
                    if (mem_rec) begin
                        byte_d       = rd_data;
                        addr_d       = addr_q + 32'd1;
                        remaining_d  = remaining_q - 32'd1;
                        rd_pending_d = 1'b0;
                    end else begin
                        byte_d        = rec_q.payload[31:24];
                        rec_d.payload = {rec_q.payload[23:0], 8'h00};
                    end
                    csum_d = csum_q + byte_d;
                    left_d = left_q - 8'd1;
                end
            end
            default: ;
        endcase
        if (rd_issue) begin
            rd_pending_d = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q        <= '0;
            remaining_q   <= '0;
            start_addr_q  <= '0;
            upper_q       <= '0;
            upper_valid_q <= 1'b0;
            sa_pending_q  <= 1'b0;
            eof_q         <= 1'b0;
            rd_pending_q  <= 1'b0;
            rec_q         <= '0;
            left_q        <= '0;
            byte_q        <= '0;
            csum_q        <= '0;
            nib_q         <= '0;
        end else begin
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            start_addr_q  <= start_addr_d;
            upper_q       <= upper_d;
            upper_valid_q <= upper_valid_d;
            sa_pending_q  <= sa_pending_d;
            eof_q         <= eof_d;
            rd_pending_q  <= rd_pending_d;
            rec_q         <= rec_d;
            left_q        <= left_d;
            byte_q        <= byte_d;
            csum_q        <= csum_d;
            nib_q         <= nib_d;
        end
    end

    // Output next values, derived from the next state so the outputs can be registered
    always_comb begin
        tx_valid_d   = state_d inside {ST_COLON, ST_HDR, ST_DHI, ST_DLO, ST_CSUM, ST_CR, ST_LF};
        tx_data_d    = char_of(state_d, nib_d, rec_d.len, rec_d.addr, rec_d.rtype, byte_d, csum_d);
        rd_req_d     = rd_issue;
        rd_address_d = rd_issue ? addr_q : rd_address;
        busy_d       = !(state_d inside {ST_IDLE, ST_DONE});
        done_d       = (state_d == ST_DONE);
    end

    // Output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
            rd_req     <= 1'b0;
            rd_address <= 32'h0000_0000;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            tx_valid   <= tx_valid_d;
            tx_data    <= tx_data_d;
            rd_req     <= rd_req_d;
            rd_address <= rd_address_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_ihex_encoder.sv
// Directed bench for ihex_encoder: compares the emitted text (CR shown as
// '_', LF as '|') against hand-computed Intel HEX files, plus handshake,
// read-port and reset behaviour.
module tb_ihex_encoder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_address = '0;
    logic [31:0] length = '0;
    logic [31:0] start_address = '0;
    logic        start_address_valid = 1'b0;
    logic        rd_req;
    logic [31:0] rd_address;
    logic [7:0]  rd_data = '0;
    logic        rd_valid = 1'b0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        done;

    always #5 clock = ~clock;

    ihex_encoder #(.RECORD_BYTES(16)) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .start              (start),
        .base_address       (base_address),
        .length             (length),
        .start_address      (start_address),
        .start_address_valid(start_address_valid),
        .rd_req             (rd_req),
        .rd_address         (rd_address),
        .rd_data            (rd_data),
        .rd_valid           (rd_valid),
        .tx_valid           (tx_valid),
        .tx_data            (tx_data),
        .tx_ready           (tx_ready),
        .busy               (busy),
        .done               (done)
    );

    int    checks = 0;
    int    errors = 0;
    string got_text = "";
    int    n_chars = 0;
    int    reads = 0;
    int    cyc = 0;
    int    hs_cyc = 0;
    logic  hold_prev = 1'b0;
    logic  [7:0] hold_data = '0;
    logic  outstanding = 1'b0;
    logic  prev_rd_req = 1'b0;
    bit    rand_delay = 1'b0;
    bit    stall_en = 1'b0;
    bit    stalled = 1'b0;

    task automatic chk(input string tag, input string got, input string exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got '%s' expected '%s'", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return 8'(a[7:0] + a[15:8] + a[23:16] + a[31:24] + 8'd1);
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Character capture, hold check and read-request discipline
    always @(negedge clock) begin
        if (!reset_n) begin
            hold_prev   = 1'b0;
            outstanding = 1'b0;
            prev_rd_req = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("tx_hold", $sformatf("%0b/%02h", tx_valid, tx_data),
                    $sformatf("1/%02h", hold_data));
            end
            hold_prev = tx_valid && !tx_ready;
            hold_data = tx_data;
            if (tx_valid && tx_ready) begin
                if (tx_data == 8'h0D) got_text = $sformatf("%s_", got_text);
                else if (tx_data == 8'h0A) got_text = $sformatf("%s|", got_text);
                else got_text = $sformatf("%s%c", got_text, tx_data);
                n_chars++;
                hs_cyc = cyc;
            end
            if (rd_req) begin
                reads++;
                chk("rd_single", $sformatf("%0b%0b", outstanding, prev_rd_req), "00");
                outstanding = 1'b1;
            end else if (rd_valid) begin
                outstanding = 1'b0;
            end
            prev_rd_req = rd_req;
        end
    end

    // Memory responder: rd_valid 1 cycle (or 1..7 random) after rd_req
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n && rd_req) begin
                automatic int d = rand_delay ? int'($urandom_range(7, 1)) : 1;
                automatic logic [31:0] a = rd_address;
                repeat (d) @(posedge clock);
                #1;
                rd_valid = 1'b1;
                rd_data  = mem_byte(a);
                @(posedge clock);
                #1;
                rd_valid = 1'b0;
                rd_data  = 8'h00;
            end
        end
    end

    // Sink back-pressure: one 5-cycle tx_ready stall mid-data when enabled
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (stall_en && !stalled && n_chars >= 30) begin
                stalled  = 1'b1;
                tx_ready = 1'b0;
                repeat (5) @(posedge clock);
                #1;
                tx_ready = 1'b1;
            end
        end
    end

    task automatic kick(input logic [31:0] b, input logic [31:0] l,
                        input logic [31:0] sa, input logic sav);
        @(posedge clock);
        #1;
        base_address        = b;
        length              = l;
        start_address       = sa;
        start_address_valid = sav;
        start               = 1'b1;
        got_text            = "";
        n_chars             = 0;
        reads               = 0;
        stalled             = 1'b0;
        @(posedge clock);
        #1;
        start = 1'b0;
        // Scramble inputs: the file must use the latched values
        base_address        = ~b;
        length              = l + 32'd7;
        start_address       = ~sa;
        start_address_valid = ~sav;
        chk("busy_after_start", $sformatf("%0b", busy), "1");
    endtask

    task automatic run_file(input logic [31:0] b, input logic [31:0] l,
                            input logic [31:0] sa, input logic sav,
                            input string exp, input int exp_reads, input string name);
        int  k;
        bit  found;
        kick(b, l, sa, sav);
        repeat (2) @(posedge clock);
        #1;
        chk({name, "_first_char"}, $sformatf("%0b/%02h", tx_valid, tx_data), "1/3a");
        // Stray start while busy must be ignored
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        k = 0;
        found = 1'b0;
        while (k < 20000 && !found) begin
            @(posedge clock);
            #1;
            k++;
            if (done) found = 1'b1;
        end
        chk({name, "_done_seen"}, $sformatf("%0b", found), "1");
        if (found) begin
            chk({name, "_done_busy"}, $sformatf("%0b", busy), "0");
            chk({name, "_done_after_lf"}, $sformatf("%0d", cyc - hs_cyc), "1");
            @(posedge clock);
            #1;
            chk({name, "_done_pulse"}, $sformatf("%0b%0b%0b", done, busy, tx_valid), "000");
        end
        chk({name, "_text"}, got_text, exp);
        chk({name, "_reads"}, $sformatf("%0d", reads), $sformatf("%0d", exp_reads));
    endtask

    localparam string EXP_T3 =
        ":020000040000FA_|:1001000002030405060708090A0B0C0D0E0F101157_|:04011000121314159D_|:00000001FF_|";
    localparam string EXP_T1 = ":020000040000FA_|:03000000010203F7_|:00000001FF_|";

    initial begin
        int k;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outputs",
            $sformatf("%0b %08h %0b %02h %0b %0b", rd_req, rd_address, tx_valid, tx_data, busy, done),
            "0 00000000 0 00 0 0");
        reset_n = 1'b1;
        repeat (2) @(posedge clock);

        run_file(32'h0000_0000, 32'd3, 32'h0, 1'b0, EXP_T1, 3, "t1");

        run_file(32'h0001_FFFE, 32'd4, 32'h0, 1'b0,
                 ":020000040001F9_|:02FFFE00FF0002_|:020000040002F8_|:020000000304F7_|:00000001FF_|",
                 4, "t2");

        run_file(32'h0000_0100, 32'd20, 32'h0, 1'b0, EXP_T3, 20, "t3");

        run_file(32'h0000_0000, 32'd0, 32'h1234_5678, 1'b1,
                 ":0400000512345678E3_|:00000001FF_|", 0, "t4");

        run_file(32'hFFFF_FFFE, 32'd4, 32'h0, 1'b0,
                 ":02000004FFFFFC_|:02FFFE00FCFD08_|:020000040000FA_|:020000000102FB_|:00000001FF_|",
                 4, "t5");

        stall_en   = 1'b1;
        rand_delay = 1'b1;
        run_file(32'h0000_0100, 32'd20, 32'h0, 1'b0, EXP_T3, 20, "t6");
        chk("t6_stall_applied", $sformatf("%0b", stalled), "1");

        // Reset in the middle of a data record
        stall_en = 1'b0;
        kick(32'h0000_0100, 32'd20, 32'h0, 1'b0);
        k = 0;
        while (n_chars < 40 && k < 2000) begin
            @(posedge clock);
            k++;
        end
        chk("t7_progress", $sformatf("%0b", n_chars >= 40), "1");
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t7_async_reset",
            $sformatf("%0b %08h %0b %02h %0b %0b", rd_req, rd_address, tx_valid, tx_data, busy, done),
            "0 00000000 0 00 0 0");
        repeat (10) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        run_file(32'h0000_0000, 32'd3, 32'h0, 1'b0, EXP_T1, 3, "t7_restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
